// File: rtl/lsu_wb_master.sv
// Wishbone B4 classic data-port master for the LSU: one single read/write per core
// request, with busy/done handshake, error pulse and an optional ack timeout watchdog.
module lsu_wb_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_SKIP = 2'd2;

    // Last counter value of a BUS cycle before the watchdog fires; unused when disabled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      dat_q, dat_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                    if (!we || (be != 4'b0000)) begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        we_d    = we;
                        adr_d   = {addr[31:2], 2'b00};
                        sel_d   = we ? be : 4'b1111;
                        dat_d   = wdata;
                    end else begin
                        // Store with an empty mask has nothing to write: complete without a bus cycle.
                        state_d = S_SKIP;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (wb_err_i) begin
                    err_d = 1'b1;
                    done_d = 1'b1;
                end else if (wb_ack_i) begin
                    done_d = 1'b1;
                    if (!we_q) rdata_d = wb_dat_i;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    rdata_d = 32'h0;
                end
                if (done_d) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    cyc_d   = 1'b0;
                end
            end
            S_SKIP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            sel_q   <= 4'h0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = dat_q;

endmodule
